// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer in front of a shared 4:1 single-bit mux.
// One requester at a time is granted. While it holds its request, the
// selected input bit is sampled into a registered output, up to HOLD_MAX
// samples per grant. After each grant a dead gap of GAP_CYCLES cycles lets
// the mux settle before the select lines can move again.
//
// Parameters
//   HOLD_MAX    maximum samples per grant (1..15)
//   GAP_CYCLES  dead cycles after a grant, before re-arbitration (0..7)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   req[3:0]   in   per-requester request, bit i <-> mux input i
//   in[3:0]    in   data bits, bit i feeds mux input i
//   s0, s1     out  mux select lines (sel[0], sel[1]), registered
//   gnt[3:0]   out  one-hot grant, zero when no grant is active
//   out        out  registered sample of in[sel]
//   out_valid  out  out was sampled at the last edge
//   busy       out  arbiter is in GRANT or GAP
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int HOLD_MAX   = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       out,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);
    localparam bit         HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [2:0] GAP_LOAD   = HAS_GAP ? 3'(GAP_CYCLES - 1) : 3'd0;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] gcnt_q, gcnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

    logic [1:0] winner;
    logic       grant_end;

    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr. Walking the offsets
    // from farthest to nearest lets the nearest set bit overwrite the rest,
    // so the just-served requester ends up with the lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gcnt_d      = gcnt_q;
        gnt_d       = gnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        winner      = rr_pick(req, ptr_q);
        grant_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No sample is taken at an arbitration edge.
                out_valid_d = 1'b0;
                if (req != 4'b0000) begin
                    sel_d   = winner;
                    ptr_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = 4'd0;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (req[sel_q]) begin
                    out_d       = in[sel_q];
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                    // The last allowed sample closes the grant at the same edge.
                    if ((cnt_q + 4'd1) == HOLD_MAX_C) begin
                        grant_end = 1'b1;
                    end
                end else begin
                    // Requester released early: no sample, out keeps its value.
                    out_valid_d = 1'b0;
                    grant_end   = 1'b1;
                end

                if (grant_end) begin
                    gnt_d = 4'b0000;
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                        gcnt_d  = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                out_valid_d = 1'b0;
                gnt_d       = 4'b0000;
                if (gcnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        // busy is registered from the next state so it lines up with state_q.
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: every register here is a small control flop, so all of them
        // are reset; reset wins over any in-flight grant or gap.
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            ptr_q       <= 2'd3;
            cnt_q       <= 4'd0;
            gcnt_q      <= 3'd0;
            gnt_q       <= 4'b0000;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            gnt_q       <= gnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign gnt       = gnt_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed bench for mux4_rr_arbiter. One instance uses the default
// parameters (HOLD_MAX=4, GAP_CYCLES=1); a second uses the minimum
// parameters (HOLD_MAX=1, GAP_CYCLES=0). Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, din;
    logic       s0, s1, dout, dout_valid, busy;
    logic [3:0] gnt;

    logic [3:0] req_m, din_m;
    logic       s0_m, s1_m, dout_m, dout_valid_m, busy_m;
    logic [3:0] gnt_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (din),
        .s0        (s0),
        .s1        (s1),
        .gnt       (gnt),
        .out       (dout),
        .out_valid (dout_valid),
        .busy      (busy)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .GAP_CYCLES(0)) u_min (
        .clk       (clk),
        .rst       (rst),
        .req       (req_m),
        .in        (din_m),
        .s0        (s0_m),
        .s1        (s1_m),
        .gnt       (gnt_m),
        .out       (dout_m),
        .out_valid (dout_valid_m),
        .busy      (busy_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected grant sequence under full contention, starting from ptr=3.
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_sel [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic       exp_out [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        din   = 4'b0000;
        req_m = 4'b0000;
        din_m = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state ----
        check("rst_gnt",   gnt,        8'h0);
        check("rst_sel",   {s1, s0},   8'h0);
        check("rst_out",   dout,       8'h0);
        check("rst_valid", dout_valid, 8'h0);
        check("rst_busy",  busy,       8'h0);

        // ---- single requester ----
        req = 4'b0001;
        din = 4'b0001;
        tick();                                   // E0
        check("single_e0_gnt",   gnt,        8'h1);
        check("single_e0_sel",   {s1, s0},   8'h0);
        check("single_e0_valid", dout_valid, 8'h0);
        check("single_e0_busy",  busy,       8'h1);
        for (int i = 1; i <= 4; i++) begin        // E1..E4
            din = (i % 2 == 1) ? 4'b0001 : 4'b0000;
            tick();
            check("single_valid", dout_valid, 8'h1);
            check("single_out",   dout,       (i % 2 == 1) ? 8'h1 : 8'h0);
        end
        check("single_e4_gnt",  gnt,  8'h0);
        check("single_e4_busy", busy, 8'h1);
        tick();                                   // E5 (gap)
        check("single_e5_gnt",   gnt,        8'h0);
        check("single_e5_valid", dout_valid, 8'h0);
        tick();                                   // E6
        check("single_e6_gnt", gnt, 8'h1);

        // ---- full contention ----
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        din = 4'b1010;
        for (int g = 0; g < 5; g++) begin
            tick();                               // grant edge
            check("rr_gnt",   gnt,        8'(exp_gnt[g]));
            check("rr_sel",   {s1, s0},   8'(exp_sel[g]));
            check("rr_valid0", dout_valid, 8'h0);
            for (int k = 0; k < 4; k++) begin
                tick();
                check("rr_valid", dout_valid, 8'h1);
                check("rr_out",   dout,       8'(exp_out[g]));
            end
            check("rr_end_gnt", gnt, 8'h0);
            tick();                               // gap
            check("rr_gap_valid", dout_valid, 8'h0);
            check("rr_gap_sel",   {s1, s0},   8'(exp_sel[g]));
        end

        // ---- reset priority ----
        req = 4'b0000;
        do_reset();
        req = 4'b1010;
        din = 4'b0000;
        tick();
        check("prio_gnt1", gnt,      8'h2);
        check("prio_sel1", {s1, s0}, 8'h1);
        repeat (5) tick();
        tick();
        check("prio_gnt3", gnt,      8'h8);
        check("prio_sel3", {s1, s0}, 8'h3);

        // ---- early release ----
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        tick();
        check("early_gnt", gnt,      8'h4);
        check("early_sel", {s1, s0}, 8'h2);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("early_valid", dout_valid, 8'h1);
            check("early_out",   dout,       8'h1);
        end
        req = 4'b0000;
        din = 4'b0000;
        tick();                                   // drop edge
        check("early_drop_gnt",   gnt,        8'h0);
        check("early_drop_valid", dout_valid, 8'h0);
        check("early_drop_out",   dout,       8'h1);
        check("early_drop_busy",  busy,       8'h1);
        tick();
        check("early_hold_out",   dout,       8'h1);
        check("early_hold_valid", dout_valid, 8'h0);
        check("early_idle_busy",  busy,       8'h0);
        check("early_hold_sel",   {s1, s0},   8'h2);

        // ---- reset mid-grant ----
        do_reset();
        req = 4'b1000;
        din = 4'b1000;
        tick();
        check("midrst_gnt", gnt, 8'h8);
        tick();                                   // first sample
        check("midrst_s1_valid", dout_valid, 8'h1);
        rst = 1'b1;
        tick();                                   // would be second sample
        rst = 1'b0;
        check("midrst_gnt0",  gnt,        8'h0);
        check("midrst_sel0",  {s1, s0},   8'h0);
        check("midrst_out0",  dout,       8'h0);
        check("midrst_valid", dout_valid, 8'h0);
        check("midrst_busy",  busy,       8'h0);
        req = 4'b1111;
        tick();
        check("midrst_regnt", gnt, 8'h1);

        // ---- minimum parameters ----
        req = 4'b0000;
        do_reset();
        req_m = 4'b0011;
        din_m = 4'b0010;
        for (int r = 0; r < 2; r++) begin
            tick();
            check("min_gnt0",   gnt_m,        8'h1);
            check("min_sel0",   {s1_m, s0_m}, 8'h0);
            check("min_valid0", dout_valid_m, 8'h0);
            tick();
            check("min_s0_valid", dout_valid_m, 8'h1);
            check("min_s0_out",   dout_m,       8'h0);
            check("min_s0_gnt",   gnt_m,        8'h0);
            check("min_s0_busy",  busy_m,       8'h0);
            tick();
            check("min_gnt1",   gnt_m,        8'h2);
            check("min_sel1",   {s1_m, s0_m}, 8'h1);
            check("min_valid1", dout_valid_m, 8'h0);
            tick();
            check("min_s1_valid", dout_valid_m, 8'h1);
            check("min_s1_out",   dout_m,       8'h1);
            check("min_s1_gnt",   gnt_m,        8'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
